// File: rtl/booth_seq_mult.sv
// Radix-4 Booth sequential multiplier controller.
// Drives an external partial-product generator and accumulates its result.
module booth_seq_mult #(
  parameter int MCAND_W = 25,
  parameter int MPLR_W  = 24,
  parameter int PP_W    = MCAND_W + 1,
  parameter int PROD_W  = MCAND_W + MPLR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MCAND_W-1:0] mcand,
  input  logic [MPLR_W-1:0]  mplr,
  output logic               busy,
  output logic [2:0]         grp,
  output logic [MCAND_W-1:0] mcand_o,
  input  logic [PP_W-1:0]    pp_in,
  output logic               done,
  output logic [PROD_W-1:0]  product
);

  localparam int N     = MPLR_W / 2;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [MPLR_W:0]     mreg_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   pp_ext;
  logic [PROD_W-1:0]   pp_sh;
  logic [PROD_W-1:0]   acc_d;
  logic                pp_sign;
  logic                last;
  logic                accept;
  logic                in_run;

  assign in_run = (state_q == S_RUN);
  assign last   = (cnt_q == CNT_W'(N - 1));
  assign accept = start && !in_run;

  // -2x of the most-negative multiplicand is +2^(PP_W-1), which wraps
  // in PP_W bits; its true sign is known from grp and mcand_o.
  assign pp_sign = (grp == 3'b100 && mcand_o[MCAND_W-1])
                 ? 1'b0
                 : pp_in[PP_W-1];

  assign pp_ext = {{(PROD_W - PP_W){pp_sign}}, pp_in};
  assign pp_sh  = pp_ext << {cnt_q, 1'b0};
  assign acc_d  = acc_q + pp_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    grp  = 3'b000;
    unique case (1'b1)
      (state_q == S_RUN): begin
        busy = 1'b1;
        grp  = mreg_q[2:0];
      end
      (state_q == S_DONE): begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_o <= '0;
      mreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else if (accept) begin
      mcand_o <= mcand;
      mreg_q  <= {mplr, 1'b0};
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (in_run) begin
      acc_q  <= acc_d;
      mreg_q <= {2'b00, mreg_q[MPLR_W:2]};
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last) product <= acc_d;
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult with a reference partial-product generator.
// Expected products are queued at launch and checked on each done pulse.
module tb_booth_seq_mult;

  localparam int MCAND_W = 25;
  localparam int MPLR_W  = 24;
  localparam int PP_W    = 26;
  localparam int PROD_W  = 49;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [MCAND_W-1:0] mcand = '0;
  logic [MPLR_W-1:0]  mplr = '0;
  logic               busy;
  logic [2:0]         grp;
  logic [MCAND_W-1:0] mcand_o;
  logic [PP_W-1:0]    pp_in;
  logic               done;
  logic [PROD_W-1:0]  product;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  logic [PROD_W-1:0] sbq[$];

  booth_seq_mult dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplr    (mplr),
    .busy    (busy),
    .grp     (grp),
    .mcand_o (mcand_o),
    .pp_in   (pp_in),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  logic [26:0] x27;
  logic [26:0] pp27;
  always_comb begin
    x27  = {{2{mcand_o[MCAND_W-1]}}, mcand_o};
    pp27 = '0;
    case (grp)
      3'b001, 3'b010: pp27 = x27;
      3'b011:         pp27 = x27 << 1;
      3'b100:         pp27 = -(x27 << 1);
      3'b101, 3'b110: pp27 = -x27;
      default:        pp27 = '0;
    endcase
    pp_in = pp27[PP_W-1:0];
  end

  function automatic logic [PROD_W-1:0] ref_mul(
    input logic [MCAND_W-1:0] a,
    input logic [MPLR_W-1:0]  b
  );
    logic signed [PROD_W-1:0] sa;
    logic signed [PROD_W-1:0] sb;
    logic signed [PROD_W-1:0] p;
    sa = {{(PROD_W - MCAND_W){a[MCAND_W-1]}}, a};
    sb = {{(PROD_W - MPLR_W){b[MPLR_W-1]}}, b};
    p  = sa * sb;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      checks++;
      assert (sbq.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_done observed=1 expected=0");
      end
      if (sbq.size() != 0) chk("sb_product", 64'(product), 64'(sbq.pop_front()));
      chk("busy_in_done", 64'(busy), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [MCAND_W-1:0] a,
                        input logic [MPLR_W-1:0] b);
    mcand = a;
    mplr  = b;
    start = 1'b1;
    sbq.push_back(ref_mul(a, b));
    acc_cnt++;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit noise, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        mcand = MCAND_W'($urandom);
        mplr  = MPLR_W'($urandom);
      end
      tick();
    end
    start = 1'b0;
  endtask

  function automatic logic [MCAND_W-1:0] rnd_a();
    case ($urandom_range(0, 7))
      0: return 25'h1000000;
      1: return 25'h0FFFFFF;
      2: return 25'h1FFFFFF;
      default: return MCAND_W'($urandom);
    endcase
  endfunction

  function automatic logic [MPLR_W-1:0] rnd_b();
    case ($urandom_range(0, 7))
      0: return 24'h800000;
      1: return 24'h7FFFFF;
      2: return 24'hFFFFFF;
      default: return MPLR_W'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    int gap;
    logic [2:0] eg;

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_grp", 64'(grp), 64'd0);
    chk("rst_mcand_o", 64'(mcand_o), 64'd0);
    chk("rst_product", 64'(product), 64'd0);

    // 3 x 5 cycle by cycle
    launch(25'd3, 24'd5);
    for (int c = 1; c <= 12; c++) begin
      eg = (c <= 2) ? 3'b010 : 3'b000;
      chk($sformatf("busy_c%0d", c), 64'(busy), 64'd1);
      chk($sformatf("grp_c%0d", c), 64'(grp), 64'(eg));
      chk($sformatf("done_c%0d", c), 64'(done), 64'd0);
      tick();
    end
    chk("done_c13", 64'(done), 64'd1);
    chk("busy_c13", 64'(busy), 64'd0);
    chk("grp_c13", 64'(grp), 64'd0);
    chk("prod_3x5", 64'(product), 64'd15);
    tick();
    chk("done_c14", 64'(done), 64'd0);
    chk("prod_hold", 64'(product), 64'd15);

    launch(25'h1FFFFFF, 24'hFFFFFF);
    wait_done(1'b0, lat);
    chk("lat_m1", 64'(lat), 64'd13);
    chk("prod_m1xm1", 64'(product), 64'd1);
    tick();

    launch(25'h1000000, 24'h800000);
    wait_done(1'b0, lat);
    chk("lat_minmin", 64'(lat), 64'd13);
    chk("prod_minmin", 64'(product), 64'h0800000000000);
    tick();

    launch(25'h1000000, 24'h7FFFFF);
    wait_done(1'b0, lat);
    chk("lat_minmax", 64'(lat), 64'd13);
    chk("prod_minmax", 64'(product), 64'h1800001000000);
    tick();

    // start ignored while busy, then back-to-back from DONE
    launch(25'd7, 24'd9);
    tick();
    tick();
    for (int c = 3; c <= 8; c++) begin
      start = 1'b1;
      mcand = 25'd11;
      mplr  = 24'd13;
      tick();
    end
    start = 1'b0;
    chk("ign_mcand_o", 64'(mcand_o), 64'd7);
    chk("ign_busy", 64'(busy), 64'd1);
    for (int c = 9; c <= 12; c++) tick();
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_prod", 64'(product), 64'd63);
    launch(25'h1FFFFFB, 24'd6);
    wait_done(1'b0, lat);
    chk("b2b_lat", 64'(lat), 64'd13);
    chk("b2b_prod", 64'(product), 64'h1FFFFFFFFFFE2);
    tick();

    // reset in the middle of an operation
    launch(25'd123, 24'hFFFFB3);
    for (int c = 1; c < 6; c++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_grp", 64'(grp), 64'd0);
    chk("mid_rst_mcand_o", 64'(mcand_o), 64'd0);
    chk("mid_rst_product", 64'(product), 64'd0);
    void'(sbq.pop_back());
    acc_cnt--;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 64'(busy), 64'd0);
    launch(25'd123, 24'hFFFFB3);
    wait_done(1'b0, lat);
    chk("post_rst_lat", 64'(lat), 64'd13);
    chk("post_rst_prod", 64'(product), 64'(ref_mul(25'd123, 24'hFFFFB3)));
    tick();

    // random operands, noisy start while busy, random gaps
    for (int i = 0; i < 2500; i++) begin
      launch(rnd_a(), rnd_b());
      wait_done(1'b1, lat);
      chk("rnd_lat", 64'(lat), 64'd13);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
    end
    tick();
    tick();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(acc_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
